// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: frame-parser state encoding and the
// default framing / timing constants.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StPayload,
    StChk,
    StDrain
  } state_e;

  localparam int unsigned ClksPerBit     = 1042;
  localparam int unsigned DefMaxLen      = 16;
  localparam logic [7:0]  DefSofByte     = 8'hA5;
  // Two full characters of idle line (10 bits each).
  localparam int unsigned DefTimeoutClks = ClksPerBit * 20;

endpackage

// File: rtl/uart_rx_frame_buf.sv
// Payload store for the frame parser: Depth x 8 register file, one synchronous write port and
// one combinational read port. Storage is not reset; only addresses below the current frame
// length are ever read.
//   clk_i     clock
//   we_i      write enable
//   waddr_i   write address
//   wdata_i   write data
//   raddr_i   read address
//   rdata_o   read data (combinational)
module uart_rx_frame_buf #(
  parameter int unsigned Depth = 16,
  parameter int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [7:0]       wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [7:0]       rdata_o
);

  logic [7:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_frame_parser.sv
// Frame parser behind uart_rx. Assembles SOF, LEN, LEN payload bytes, CHK (XOR of LEN and
// payload), buffers verified payloads and replays them on a valid/ready byte stream.
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_rx_dv, i_rx_byte one-cycle byte strobe and byte from uart_rx
//   o_data, o_valid, i_ready, o_last   payload stream (o_data is 0 while o_valid is low)
//   o_frame_ok, o_err_chk, o_err_len, o_err_timeout, o_drop   one-cycle status pulses
//   o_busy             parser is not idle
module uart_rx_frame_parser
  import uart_pkg::*;
#(
  parameter int unsigned MAX_LEN      = DefMaxLen,
  parameter logic [7:0]  SOF_BYTE     = DefSofByte,
  parameter int unsigned TIMEOUT_CLKS = DefTimeoutClks
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx_dv,
  input  logic [7:0] i_rx_byte,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_last,
  output logic       o_frame_ok,
  output logic       o_err_chk,
  output logic       o_err_len,
  output logic       o_err_timeout,
  output logic       o_drop,
  output logic       o_busy
);

  localparam int unsigned GapW  = $clog2(TIMEOUT_CLKS + 1);
  localparam int unsigned AddrW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]      MaxLenB = 8'(MAX_LEN);
  localparam logic [GapW-1:0] GapLast = GapW'(TIMEOUT_CLKS - 1);

  state_e          state_q, state_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      chk_q, chk_d;
  logic [7:0]      wr_idx_q, wr_idx_d;
  logic [7:0]      rd_idx_q, rd_idx_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic            frame_ok_q, frame_ok_d;
  logic            err_chk_q, err_chk_d;
  logic            err_len_q, err_len_d;
  logic            err_to_q, err_to_d;
  logic            drop_q, drop_d;

  logic       buf_we;
  logic [7:0] buf_rdata;
  logic       drain_last;
  logic       in_frame;

  uart_rx_frame_buf #(
    .Depth (MAX_LEN)
  ) u_buf (
    .clk_i   (i_clk),
    .we_i    (buf_we),
    .waddr_i (wr_idx_q[AddrW-1:0]),
    .wdata_i (i_rx_byte),
    .raddr_i (rd_idx_q[AddrW-1:0]),
    .rdata_o (buf_rdata)
  );

  assign drain_last = (rd_idx_q == len_q - 8'd1);
  assign in_frame   = (state_q == StLen) || (state_q == StPayload) || (state_q == StChk);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    chk_d      = chk_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    gap_d      = gap_q;
    buf_we     = 1'b0;
    frame_ok_d = 1'b0;
    err_chk_d  = 1'b0;
    err_len_d  = 1'b0;
    err_to_d   = 1'b0;
    drop_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_rx_dv && (i_rx_byte == SOF_BYTE)) begin
          state_d = StLen;
          gap_d   = '0;
        end
      end
      StLen: begin
        if (i_rx_dv) begin
          gap_d = '0;
          if ((i_rx_byte == 8'd0) || (i_rx_byte > MaxLenB)) begin
            err_len_d = 1'b1;
            state_d   = StIdle;
          end else begin
            len_d    = i_rx_byte;
            chk_d    = i_rx_byte;
            wr_idx_d = '0;
            state_d  = StPayload;
          end
        end
      end
      StPayload: begin
        if (i_rx_dv) begin
          gap_d    = '0;
          buf_we   = 1'b1;
          chk_d    = chk_q ^ i_rx_byte;
          wr_idx_d = wr_idx_q + 8'd1;
          if (wr_idx_q == len_q - 8'd1) begin
            state_d = StChk;
          end
        end
      end
      StChk: begin
        if (i_rx_dv) begin
          gap_d = '0;
          if (i_rx_byte == chk_q) begin
            state_d    = StDrain;
            rd_idx_d   = '0;
            frame_ok_d = 1'b1;
          end else begin
            err_chk_d = 1'b1;
            state_d   = StIdle;
          end
        end
      end
      StDrain: begin
        // Nothing is received while draining; SOF included.
        if (i_rx_dv) begin
          drop_d = 1'b1;
        end
        if (i_ready) begin
          if (drain_last) begin
            state_d = StIdle;
          end else begin
            rd_idx_d = rd_idx_q + 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Inter-byte gap timer. A byte landing in the limit cycle wins over the timeout.
    if (in_frame && !i_rx_dv) begin
      if (gap_q == GapLast) begin
        err_to_d = 1'b1;
        state_d  = StIdle;
      end else begin
        gap_d = gap_q + GapW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      len_q      <= '0;
      chk_q      <= '0;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      gap_q      <= '0;
      frame_ok_q <= 1'b0;
      err_chk_q  <= 1'b0;
      err_len_q  <= 1'b0;
      err_to_q   <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      chk_q      <= chk_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      gap_q      <= gap_d;
      frame_ok_q <= frame_ok_d;
      err_chk_q  <= err_chk_d;
      err_len_q  <= err_len_d;
      err_to_q   <= err_to_d;
      drop_q     <= drop_d;
    end
  end

  assign o_valid       = (state_q == StDrain);
  assign o_data        = o_valid ? buf_rdata : 8'h00;
  assign o_last        = o_valid && drain_last;
  assign o_busy        = (state_q != StIdle);
  assign o_frame_ok    = frame_ok_q;
  assign o_err_chk     = err_chk_q;
  assign o_err_len     = err_len_q;
  assign o_err_timeout = err_to_q;
  assign o_drop        = drop_q;

endmodule
